// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - op codes, widths, LSU state encoding and op-class helpers
package mem_lsu_pkg;

  localparam int ALU_OP_W  = 8;
  localparam int BUS_SEL_W = 4;

  localparam logic [ALU_OP_W-1:0] NOP_OP  = 8'h00;
  localparam logic [ALU_OP_W-1:0] ADDU_OP = 8'h21;
  localparam logic [ALU_OP_W-1:0] LB_OP   = 8'he0;
  localparam logic [ALU_OP_W-1:0] LH_OP   = 8'he1;
  localparam logic [ALU_OP_W-1:0] LW_OP   = 8'he3;
  localparam logic [ALU_OP_W-1:0] LBU_OP  = 8'he4;
  localparam logic [ALU_OP_W-1:0] LHU_OP  = 8'he5;
  localparam logic [ALU_OP_W-1:0] SB_OP   = 8'he8;
  localparam logic [ALU_OP_W-1:0] SH_OP   = 8'he9;
  localparam logic [ALU_OP_W-1:0] SW_OP   = 8'heb;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
    return (op == LB_OP) || (op == LBU_OP) || (op == LH_OP) ||
           (op == LHU_OP) || (op == LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [ALU_OP_W-1:0] op);
    return (op == SB_OP) || (op == SH_OP) || (op == SW_OP);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian byte-lane select, store replication, misalign and load extension
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          reg2_i,
  input  logic [31:0]          rdata_i,
  output logic [BUS_SEL_W-1:0] sel_o,
  output logic [31:0]          wdata_o,
  output logic                 misalign_o,
  output logic [31:0]          load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/halfword (address 0 lives in bits 31:24) and decode lanes per op
  always_comb begin
    sel_o       = '0;
    wdata_o     = '0;
    misalign_o  = 1'b0;
    load_data_o = '0;
    w_byte      = '0;
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[31:24];
      2'd1:    w_byte = rdata_i[23:16];
      2'd2:    w_byte = rdata_i[15:8];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    case (aluop_i)
      LB_OP: begin
        sel_o       = 4'b1000 >> addr_lo_i;
        load_data_o = {{24{w_byte[7]}}, w_byte};
      end
      LBU_OP: begin
        sel_o       = 4'b1000 >> addr_lo_i;
        load_data_o = {24'd0, w_byte};
      end
      LH_OP: begin
        misalign_o  = addr_lo_i[0];
        sel_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        load_data_o = {{16{w_half[15]}}, w_half};
      end
      LHU_OP: begin
        misalign_o  = addr_lo_i[0];
        sel_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        load_data_o = {16'd0, w_half};
      end
      LW_OP: begin
        misalign_o  = |addr_lo_i;
        sel_o       = 4'b1111;
        load_data_o = rdata_i;
      end
      SB_OP: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{reg2_i[7:0]}};
      end
      SH_OP: begin
        misalign_o = addr_lo_i[0];
        sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o    = {2{reg2_i[15:0]}};
      end
      SW_OP: begin
        misalign_o = |addr_lo_i;
        sel_o      = 4'b1111;
        wdata_o    = reg2_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: one bus transaction per memory op, pipeline stall until ack
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          reg2_i,
  input  logic [4:0]           wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          wdata_i,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 stall_req_o,
  output logic                 misalign_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_o,
  output logic [BUS_SEL_W-1:0] bus_sel_o,
  output logic [31:0]          bus_wdata_o,
  input  logic [31:0]          bus_rdata_i,
  input  logic                 bus_ack_i
);

  lsu_state_e             r_state;
  lsu_state_e             w_next;
  logic [31:0]            r_load_q;
  logic                   r_bus_req;
  logic                   r_bus_we;
  logic [31:0]            r_bus_addr;
  logic [BUS_SEL_W-1:0]   r_bus_sel;
  logic [31:0]            r_bus_wdata;

  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_is_mem;
  logic                   w_misalign_raw;
  logic                   w_misalign;
  logic                   w_start;
  logic [BUS_SEL_W-1:0]   w_sel;
  logic [31:0]            w_wdata;
  logic [31:0]            w_load_data;

  assign w_is_load  = is_load_op(aluop_i);
  assign w_is_store = is_store_op(aluop_i);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = w_is_mem & w_misalign_raw;
  assign w_start    = (r_state == LSU_IDLE) & w_is_mem & ~w_misalign_raw;

  lsu_lane_align u_lane_align (
    .aluop_i     (aluop_i),
    .addr_lo_i   (mem_addr_i[1:0]),
    .reg2_i      (reg2_i),
    .rdata_i     (bus_rdata_i),
    .sel_o       (w_sel),
    .wdata_o     (w_wdata),
    .misalign_o  (w_misalign_raw),
    .load_data_o (w_load_data)
  );

  // FSM state register; reset aborts any outstanding transaction
  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  // Next state: start on an aligned memory op, wait for ack, one DONE cycle for writeback
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: if (w_start) w_next = LSU_BUSY;
      LSU_BUSY: if (bus_ack_i) w_next = LSU_DONE;
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  // Bus request registers and load result capture; bus fields stay frozen while BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
      r_load_q    <= '0;
    end else if (w_start) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_is_store;
      r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
      r_bus_sel   <= w_sel;
      r_bus_wdata <= w_wdata;
    end else if ((r_state == LSU_BUSY) && bus_ack_i) begin
      r_bus_req <= 1'b0;
      if (w_is_load) r_load_q <= w_load_data;
    end
  end

  // Writeback triple, stall and misalign; all forced low while in reset
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    if (!rst) begin
      wd_o        = wd_i;
      wreg_o      = wreg_i & ~w_is_store & ~w_misalign;
      wdata_o     = ((r_state == LSU_DONE) && w_is_load) ? r_load_q : wdata_i;
      stall_req_o = w_start | (r_state == LSU_BUSY);
      misalign_o  = w_misalign;
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_sel_o   = r_bus_sel;
  assign bus_wdata_o = r_bus_wdata;

endmodule
